// File: rtl/fetch_unit_pkg.sv
// Shared types for the fetch stage: address/data words and the next-PC select encoding.
// Imported by the fetch unit, its next-PC helper, and any verification model that reuses them.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] data_t;

  typedef enum logic [1:0] {
    SEL_PC_NONE   = 2'd0,
    SEL_PC_PLUS4  = 2'd1,
    SEL_PC_JUMP   = 2'd2,
    SEL_PC_BRANCH = 2'd3
  } sel_pc_t;

  localparam addr_t PC_STEP = addr_t'(4);

  // Instruction memory is word-addressed, so the two low bits never reach the bus.
  function automatic addr_t align_word(input addr_t a);
    return {a[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_pc_next_calc.sv
// Combinational next-PC selection with word alignment and a misalignment flag.
// Kept free of state so a reference model can instantiate it directly.
module pc_next_calc
  import fetch_unit_pkg::*;
(
  input  addr_t   pc,
  input  sel_pc_t pc_sel,
  input  logic    br_taken,
  input  addr_t   next_pc,
  output logic    update,
  output addr_t   target,
  output logic    misalign
);

  addr_t raw_target;

  // Sequential fetch wraps silently at the top of the address space.
  always_comb begin
    raw_target = pc + PC_STEP;
    update     = 1'b1;
    case (pc_sel)
      SEL_PC_NONE: begin
        raw_target = pc;
        update     = 1'b0;
      end
      SEL_PC_PLUS4:  raw_target = pc + PC_STEP;
      SEL_PC_JUMP:   raw_target = next_pc;
      SEL_PC_BRANCH: raw_target = br_taken ? next_pc : (pc + PC_STEP);
      default: begin
        raw_target = pc;
        update     = 1'b0;
      end
    endcase
  end

  assign target   = align_word(raw_target);
  assign misalign = update & (|raw_target[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Non-pipelined instruction fetch: owns the PC, issues one imem read at a time and
// holds the returned word as IR until control selects the next PC.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000,
  parameter data_t NOP_INSN = 32'h0000_0013
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    fetch_stall_i,
  input  sel_pc_t pc_sel_i,
  input  logic    br_taken_i,
  input  addr_t   next_pc_i,
  output logic    imem_req_o,
  output addr_t   imem_addr_o,
  input  logic    imem_ready_i,
  input  logic    imem_rvalid_i,
  input  data_t   imem_rdata_i,
  output data_t   ir_o,
  output addr_t   pc_o,
  output logic    ir_valid_o,
  output logic    misalign_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
  } state_t;

  state_t state;
  logic   pc_update;
  addr_t  pc_target;
  logic   pc_misalign;
  logic   advance;

  pc_next_calc u_pc_next_calc (
    .pc       (pc_o),
    .pc_sel   (pc_sel_i),
    .br_taken (br_taken_i),
    .next_pc  (next_pc_i),
    .update   (pc_update),
    .target   (pc_target),
    .misalign (pc_misalign)
  );

  // Control inputs only matter once an instruction is held; elsewhere they are don't-care.
  assign advance = (state == ST_HOLD) && !fetch_stall_i && pc_update;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      pc_o        <= RESET_PC;
      ir_o        <= NOP_INSN;
      ir_valid_o  <= 1'b0;
      imem_req_o  <= 1'b0;
      imem_addr_o <= RESET_PC;
      misalign_o  <= 1'b0;
    end else begin
      misalign_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          imem_req_o  <= 1'b1;
          imem_addr_o <= pc_o;
          state       <= ST_REQ;
        end
        ST_REQ: begin
          // Request and address stay frozen until the memory accepts them.
          if (imem_ready_i) begin
            imem_req_o <= 1'b0;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Any rvalid seen while still in REQ belongs to nobody and is dropped.
          if (imem_rvalid_i) begin
            ir_o       <= imem_rdata_i;
            ir_valid_o <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (advance) begin
            pc_o        <= pc_target;
            imem_addr_o <= pc_target;
            imem_req_o  <= 1'b1;
            ir_o        <= NOP_INSN;
            ir_valid_o  <= 1'b0;
            misalign_o  <= pc_misalign;
            state       <= ST_REQ;
          end
        end
        default: begin
          state      <= ST_IDLE;
          imem_req_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
